// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WRITE_BACK = 2'd1,
      MEM_RD     = 2'd2
   } dc_state_t;

   localparam int TAG_W    = 25;
   localparam int INDEX_W  = 3;
   localparam int OFFSET_W = 4;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   localparam logic [1:0] ST_SB = 2'b00;
   localparam logic [1:0] ST_SH = 2'b01;
   localparam logic [1:0] ST_SW = 2'b10;

   // Byte enables within one 32-bit word; halfwords use bit 1 only, words ignore both bits.
   function automatic logic [3:0] st_byte_en(input logic [1:0] size, input logic [1:0] off);
      case (size)
         ST_SB:   return 4'b0001 << off;
         ST_SH:   return off[1] ? 4'b1100 : 4'b0011;
         ST_SW:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/dcache_wb_dm_if.sv
// CPU-side request/response and main-memory block transfer signals of the data cache.
interface dcache_wb_dm_if;
   logic [3:0]   memReadEn;
   logic [2:0]   memWriteEn;
   logic [31:0]  DATA_CACHE_ADDR;
   logic [31:0]  DATA_CACHE_DATA;
   logic [31:0]  DATA_CACHE_READ_DATA;
   logic         DATA_CACHE_BUSY_WAIT;
   logic         MEM_READ;
   logic         MEM_WRITE;
   logic [27:0]  MEM_ADDR;
   logic [127:0] MEM_WRITE_DATA;
   logic [127:0] MEM_READ_DATA;
   logic         MEM_BUSY_WAIT;

   modport slave (
      input  memReadEn, memWriteEn, DATA_CACHE_ADDR, DATA_CACHE_DATA,
             MEM_READ_DATA, MEM_BUSY_WAIT,
      output DATA_CACHE_READ_DATA, DATA_CACHE_BUSY_WAIT,
             MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA
   );

   modport master (
      output memReadEn, memWriteEn, DATA_CACHE_ADDR, DATA_CACHE_DATA,
             MEM_READ_DATA, MEM_BUSY_WAIT,
      input  DATA_CACHE_READ_DATA, DATA_CACHE_BUSY_WAIT,
             MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITE_DATA
   );
endinterface

// File: rtl/dcache_byte_lane.sv
// Combinational word/byte selection with load extension, and store byte-lane merge into a 16-byte line.
module dcache_byte_lane
   import dcache_pkg::*;
(
   input  logic [127:0] line,
   input  logic [3:0]   offset,
   input  logic [2:0]   ld_funct,
   input  logic [1:0]   st_size,
   input  logic [31:0]  st_data,
   output logic [31:0]  ld_data,
   output logic [127:0] line_merged
);
   logic [31:0] word;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] st_repl;
   logic [15:0] byte_en;

   always_comb begin
      word     = line[{offset[3:2], 5'd0} +: 32];
      byte_sel = word[{offset[1:0], 3'd0} +: 8];
      half_sel = word[{offset[1], 4'd0} +: 16];
      case (ld_funct)
         LD_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
         LD_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
         LD_LBU:  ld_data = {24'd0, byte_sel};
         LD_LHU:  ld_data = {16'd0, half_sel};
         default: ld_data = word;
      endcase
   end

   // Store data is replicated across the word so every enabled lane sees its own byte.
   always_comb begin
      case (st_size)
         ST_SB:   st_repl = {4{st_data[7:0]}};
         ST_SH:   st_repl = {2{st_data[15:0]}};
         default: st_repl = st_data;
      endcase
      byte_en     = {12'd0, st_byte_en(st_size, offset[1:0])} << {offset[3:2], 2'b00};
      line_merged = line;
      for (int b = 0; b < 16; b++) begin
         if (byte_en[b]) line_merged[b*8 +: 8] = st_repl[(b%4)*8 +: 8];
      end
   end
endmodule

// File: rtl/dcache_wb_dm.sv
// Direct-mapped write-back/write-allocate data cache: zero-wait hits, misses stall via DATA_CACHE_BUSY_WAIT.
// Define DCACHE_STATS_EN to add the access_count/miss_count outputs.
module dcache_wb_dm
   import dcache_pkg::*;
#(
   parameter int LINES       = 8,
   parameter int BLOCK_WORDS = 4
) (
   input logic           CLK,
   input logic           RESET,
   dcache_wb_dm_if.slave bus
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]   access_count,
   output logic [31:0]   miss_count
`endif
);
   localparam int IW         = $clog2(LINES);
   localparam int TW         = 32 - OFFSET_W - IW;
   localparam int BLOCK_BITS = BLOCK_WORDS * 32;

   logic [BLOCK_BITS-1:0] data_arr [LINES];
   logic [TW-1:0]         tag_arr  [LINES];
   logic [LINES-1:0]      valid;
   logic [LINES-1:0]      dirty;
   dc_state_t             state;

   logic                  mem_read_r;
   logic                  mem_write_r;
   logic [27:0]           mem_addr_r;
   logic [BLOCK_BITS-1:0] mem_wdata_r;

   logic [IW-1:0]  idx;
   logic [TW-1:0]  req_tag;
   logic           st_req, ld_req, req, hit, store_commit, refill;
   logic [31:0]    ld_data;
   logic [127:0]   line_merged;

   assign idx          = bus.DATA_CACHE_ADDR[OFFSET_W +: IW];
   assign req_tag      = bus.DATA_CACHE_ADDR[31 -: TW];
   assign st_req       = bus.memWriteEn[2];
   assign ld_req       = bus.memReadEn[3] && !st_req;
   assign req          = st_req || bus.memReadEn[3];
   assign hit          = valid[idx] && (tag_arr[idx] == req_tag);
   assign store_commit = (state == IDLE) && st_req && hit;
   assign refill       = (state == MEM_RD) && !bus.MEM_BUSY_WAIT;

   dcache_byte_lane u_lane (
      .line        (data_arr[idx]),
      .offset      (bus.DATA_CACHE_ADDR[3:0]),
      .ld_funct    (bus.memReadEn[2:0]),
      .st_size     (bus.memWriteEn[1:0]),
      .st_data     (bus.DATA_CACHE_DATA),
      .ld_data     (ld_data),
      .line_merged (line_merged)
   );

   assign bus.DATA_CACHE_READ_DATA = ld_req ? ld_data : 32'd0;
   // Gated by RESET so an aborted transfer releases the pipeline even while the request is held.
   assign bus.DATA_CACHE_BUSY_WAIT = !RESET && ((state != IDLE) || (req && !hit));
   assign bus.MEM_READ             = mem_read_r;
   assign bus.MEM_WRITE            = mem_write_r;
   assign bus.MEM_ADDR             = mem_addr_r;
   assign bus.MEM_WRITE_DATA       = mem_wdata_r;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state       <= IDLE;
         valid       <= '0;
         dirty       <= '0;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (store_commit) begin
                  dirty[idx] <= 1'b1;
               end else if (req && !hit) begin
                  if (valid[idx] && dirty[idx]) begin
                     state       <= WRITE_BACK;
                     mem_write_r <= 1'b1;
                     mem_addr_r  <= {tag_arr[idx], idx};
                     mem_wdata_r <= data_arr[idx];
                  end else begin
                     state      <= MEM_RD;
                     mem_read_r <= 1'b1;
                     mem_addr_r <= bus.DATA_CACHE_ADDR[31:4];
                  end
               end
            end
            WRITE_BACK: begin
               if (!bus.MEM_BUSY_WAIT) begin
                  state       <= MEM_RD;
                  mem_write_r <= 1'b0;
                  mem_read_r  <= 1'b1;
                  mem_addr_r  <= bus.DATA_CACHE_ADDR[31:4];
               end
            end
            MEM_RD: begin
               if (!bus.MEM_BUSY_WAIT) begin
                  state      <= IDLE;
                  mem_read_r <= 1'b0;
                  valid[idx] <= 1'b1;
                  dirty[idx] <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Line storage carries no reset; validity is owned by the valid bits above.
   always_ff @(posedge CLK) begin
      if (store_commit) begin
         data_arr[idx] <= line_merged;
      end else if (refill) begin
         data_arr[idx] <= bus.MEM_READ_DATA;
         tag_arr[idx]  <= req_tag;
      end
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         access_count <= 32'd0;
         miss_count   <= 32'd0;
      end else if (state == IDLE && req) begin
         if (hit) access_count <= access_count + 32'd1;
         else     miss_count   <= miss_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_dcache_wb_dm.sv
// Bench for dcache_wb_dm: directed vector table, reset-abort sequence, then random traffic against a flat byte-memory model.
module tb_dcache_wb_dm;
   logic CLK = 1'b0;
   logic RESET;
   dcache_wb_dm_if bus ();
`ifdef DCACHE_STATS_EN
   logic [31:0] access_count, miss_count;
`endif

   dcache_wb_dm #(.LINES(8), .BLOCK_WORDS(4)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
`ifdef DCACHE_STATS_EN
      ,
      .access_count (access_count),
      .miss_count   (miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Initial memory image: a hash pattern everywhere, block 0x4 word 0 preset to DEADBEEF.
   function automatic logic [31:0] pat_word(input logic [27:0] b, input logic [1:0] w);
      logic [31:0] x;
      x = {b, w, 2'b01};
      return (x * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [127:0] init_blk(input logic [27:0] b);
      logic [127:0] blk;
      for (int w = 0; w < 4; w++) blk[w*32 +: 32] = pat_word(b, 2'(w));
      if (b == 28'h4) blk[31:0] = 32'hDEAD_BEEF;
      return blk;
   endfunction

   // Main memory model
   logic [127:0] mem [logic [27:0]];
   logic [28:0]  mem_log [$];
   int fixed_lat = 2;
   int mem_lat, mem_cnt;
   bit mem_active = 0;

   function automatic logic [127:0] mem_blk(input logic [27:0] b);
      if (mem.exists(b)) return mem[b];
      return init_blk(b);
   endfunction

   always @(negedge CLK) begin
      if (RESET || !(bus.MEM_READ || bus.MEM_WRITE)) begin
         mem_active        = 0;
         bus.MEM_BUSY_WAIT = 1'b0;
         bus.MEM_READ_DATA = '0;
      end else begin
         if (!mem_active) begin
            mem_active = 1;
            mem_cnt    = 0;
            mem_lat    = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
         end
         if (mem_cnt < mem_lat) begin
            bus.MEM_BUSY_WAIT = 1'b1;
            mem_cnt++;
         end else begin
            bus.MEM_BUSY_WAIT = 1'b0;
            mem_active        = 0;
            if (bus.MEM_WRITE) begin
               mem[bus.MEM_ADDR] = bus.MEM_WRITE_DATA;
               mem_log.push_back({1'b1, bus.MEM_ADDR});
            end else begin
               bus.MEM_READ_DATA = mem_blk(bus.MEM_ADDR);
               mem_log.push_back({1'b0, bus.MEM_ADDR});
            end
         end
      end
   end

   // Reference: the cache is invisible, so the CPU sees a flat little-endian byte memory.
   logic [7:0] ref_bytes [logic [31:0]];

   function automatic logic [7:0] ref_byte(input logic [31:0] a);
      logic [127:0] blk;
      if (ref_bytes.exists(a)) return ref_bytes[a];
      blk = init_blk(a[31:4]);
      return blk[{a[3:0], 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] w;
      b = ref_byte(a);
      h = {ref_byte({a[31:1], 1'b1}), ref_byte({a[31:1], 1'b0})};
      w = {ref_byte({a[31:2], 2'd3}), ref_byte({a[31:2], 2'd2}),
           ref_byte({a[31:2], 2'd1}), ref_byte({a[31:2], 2'd0})};
      case (f)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return w;
      endcase
   endfunction

   task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      case (sz)
         2'b00: ref_bytes[a] = d[7:0];
         2'b01: begin
            ref_bytes[{a[31:1], 1'b0}] = d[7:0];
            ref_bytes[{a[31:1], 1'b1}] = d[15:8];
         end
         default: for (int i = 0; i < 4; i++) ref_bytes[{a[31:2], 2'b00} + 32'(i)] = d[i*8 +: 8];
      endcase
   endtask

   // One CPU access held until BUSY is low, then released after the committing edge.
   task automatic access(input logic [3:0] re, input logic [2:0] we, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output int stalls);
      @(negedge CLK);
      bus.memReadEn       = re;
      bus.memWriteEn      = we;
      bus.DATA_CACHE_ADDR = a;
      bus.DATA_CACHE_DATA = d;
      #1;
      stalls = 0;
      while (bus.DATA_CACHE_BUSY_WAIT === 1'b1 && stalls < 100) begin
         @(negedge CLK);
         #1;
         stalls++;
      end
      if (stalls >= 100) begin
         n_chk++;
         n_fail++;
         $display("FAIL access_timeout: addr %h busy after %0d cycles, required release", a, stalls);
      end
      rd = bus.DATA_CACHE_READ_DATA;
      @(posedge CLK);
      #1;
      bus.memReadEn  = 4'd0;
      bus.memWriteEn = 3'd0;
   endtask

   typedef struct {
      logic [3:0]  re;
      logic [2:0]  we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_rd;
      int          exp_stalls;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]  rd;
      int           stalls, k;
      logic [127:0] exp_blk;
      logic [3:0]   re;
      logic [2:0]   we;
      logic [31:0]  a, d;
      logic [2:0]   lfun [5];

      // Each memory transfer costs its busy cycles plus a completing cycle; latency fixed at 2 here.
      vecs[0] = '{4'b1010, 3'b000, 32'h40, 32'h0,  32'hDEAD_BEEF, 1 + 3};
      vecs[1] = '{4'b1000, 3'b000, 32'h43, 32'h0,  32'hFFFF_FFDE, 0};
      vecs[2] = '{4'b1100, 3'b000, 32'h43, 32'h0,  32'h0000_00DE, 0};
      vecs[3] = '{4'b1001, 3'b000, 32'h42, 32'h0,  32'hFFFF_DEAD, 0};
      vecs[4] = '{4'b1101, 3'b000, 32'h40, 32'h0,  32'h0000_BEEF, 0};
      vecs[5] = '{4'b0000, 3'b100, 32'h41, 32'h12, 32'h0000_0000, 0};
      vecs[6] = '{4'b1010, 3'b000, 32'h40, 32'h0,  32'hDEAD_12EF, 0};
      vecs[7] = '{4'b1010, 3'b000, 32'hC0, 32'h0,  32'h0,         1 + 3 + 3};
      vecs[7].exp_rd = pat_word(28'hC, 2'd0);

      RESET               = 1'b1;
      bus.memReadEn       = 4'd0;
      bus.memWriteEn      = 3'd0;
      bus.DATA_CACHE_ADDR = 32'd0;
      bus.DATA_CACHE_DATA = 32'd0;
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      #1;
      check("rst_mem_read",   128'(bus.MEM_READ), 128'(0));
      check("rst_mem_write",  128'(bus.MEM_WRITE), 128'(0));
      check("rst_mem_addr",   128'(bus.MEM_ADDR), 128'(0));
      check("rst_mem_wdata",  bus.MEM_WRITE_DATA, 128'(0));
      check("rst_busy",       128'(bus.DATA_CACHE_BUSY_WAIT), 128'(0));
      check("rst_read_data",  128'(bus.DATA_CACHE_READ_DATA), 128'(0));

      for (int i = 0; i < 8; i++) begin
         access(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].data, rd, stalls);
         if (vecs[i].we[2]) ref_store(vecs[i].we[1:0], vecs[i].addr, vecs[i].data);
         check($sformatf("vec%0d_rdata", i), 128'(rd), 128'(vecs[i].exp_rd));
         check($sformatf("vec%0d_stalls", i), 128'(stalls), 128'(vecs[i].exp_stalls));
      end

      check("mem_log_len", 128'(mem_log.size()), 128'(3));
      if (mem_log.size() == 3) begin
         check("log0_refill_0x40", 128'(mem_log[0]), 128'({1'b0, 28'h4}));
         check("log1_writeback",   128'(mem_log[1]), 128'({1'b1, 28'h4}));
         check("log2_refill_0xC0", 128'(mem_log[2]), 128'({1'b0, 28'hC}));
      end
      exp_blk       = init_blk(28'h4);
      exp_blk[31:0] = 32'hDEAD_12EF;
      check("victim_block", mem_blk(28'h4), exp_blk);
`ifdef DCACHE_STATS_EN
      check("stats_access", 128'(access_count), 128'(8));
      check("stats_miss",   128'(miss_count), 128'(2));
`endif

      // Reset in the middle of a refill
      fixed_lat = 5;
      @(negedge CLK);
      bus.memReadEn       = 4'b1010;
      bus.DATA_CACHE_ADDR = 32'h40;
      #1;
      k = 0;
      while (bus.MEM_READ !== 1'b1 && k < 20) begin
         @(negedge CLK);
         #1;
         k++;
      end
      check("abort_mem_read_up", 128'(bus.MEM_READ), 128'(1));
      check("abort_mem_addr",    128'(bus.MEM_ADDR), 128'(28'h4));
      #2;
      RESET = 1'b1;
      #1;
      check("abort_mem_read_drop", 128'(bus.MEM_READ), 128'(0));
      check("abort_busy_drop",     128'(bus.DATA_CACHE_BUSY_WAIT), 128'(0));
      bus.memReadEn = 4'd0;
      @(negedge CLK);
      RESET     = 1'b0;
      fixed_lat = 2;
      access(4'b1010, 3'b000, 32'h40, 32'h0, rd, stalls);
      check("after_abort_rdata",  128'(rd), 128'(32'hDEAD_12EF));
      check("after_abort_stalls", 128'(stalls), 128'(4));

      // Random traffic over 1 KiB so several tags fight for each index.
      fixed_lat = -1;
      lfun = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      for (int n = 0; n < 400; n++) begin
         k = int'($urandom_range(0, 7));
         a = 32'($urandom_range(0, 1023));
         d = $urandom;
         if (k < 5) begin
            re = {1'b1, lfun[k]};
            access(re, 3'b000, a, d, rd, stalls);
            check("rand_load", 128'(rd), 128'(ref_load(lfun[k], a)));
            access(re, 3'b000, a, d, rd, stalls);
            check("rand_reload_stalls", 128'(stalls), 128'(0));
         end else begin
            we = {1'b1, 2'(k - 5)};
            access(4'b0000, we, a, d, rd, stalls);
            ref_store(we[1:0], a, d);
            check("rand_store_rdata", 128'(rd), 128'(0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
